// File: rtl/linescanner_pixel_capture.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : linescanner_pixel_capture
// Description : Line-scan sensor driver; divided sensor clock, SI pulse and
//               per-pixel ADC capture with a one-cycle strobe.
//               Optional macro LINESCANNER_TEST_PATTERN_EN replaces ADC data
//               with the pixel index.
// Revision    : 1.0 - initial release
// ============================================================================
module linescanner_pixel_capture #(
  parameter int CLK_DIV         = 4,
  parameter int PIXELS_PER_LINE = 1024,
  parameter int SAMPLE_DELAY    = 2,
  parameter int LINE_GAP        = 16
) (
  input  logic       axi_aclk,
  input  logic       axi_aresetn,
  input  logic       enable,
  input  logic [7:0] adc_data,
  output logic       sensor_clk,
  output logic       sensor_si,
  output logic [7:0] pixel_data,
  output logic       pixel_captured,
  output logic       pixel_last,
  output logic       busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PIX_W = $clog2(PIXELS_PER_LINE);
  localparam int GAP_W = (LINE_GAP > 0) ? $clog2(LINE_GAP + 1) : 1;

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);
  localparam logic [PIX_W-1:0] c_pix_last = PIX_W'(PIXELS_PER_LINE - 1);
  localparam logic [GAP_W-1:0] c_gap_end  = GAP_W'(LINE_GAP);
  localparam logic             c_no_gap   = (LINE_GAP == 0);
  // Sample point expressed as (sensor_clk level, divider count) within the period
  localparam logic             c_smp_high = (SAMPLE_DELAY < CLK_DIV);
  localparam logic [DIV_W-1:0] c_smp_div  =
    DIV_W'((SAMPLE_DELAY < CLK_DIV) ? SAMPLE_DELAY : SAMPLE_DELAY - CLK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       data_q, data_d;
  logic             sclk_q, sclk_d;
  logic             si_q, si_d;
  logic             armed_q, armed_d;
  logic             again_q, again_d;
  logic             cap_q, cap_d;
  logic             last_q, last_d;

  logic             w_tick, w_rise, w_fall, w_sample, w_pix_last, w_gap_done, w_again;
  logic [7:0]       w_sample_val;

`ifdef LINESCANNER_TEST_PATTERN_EN
  assign w_sample_val = 8'(pix_q);
`else
  assign w_sample_val = adc_data;
`endif

  always_comb begin
    w_tick     = (state_q != ST_IDLE) && (div_q == c_div_last);
    w_rise     = w_tick && !sclk_q;
    w_fall     = w_tick && sclk_q;
    // armed_q ties each sample to a rise seen in READ, never to the SI rise
    w_sample   = (state_q == ST_READ) && armed_q &&
                 (sclk_q == c_smp_high) && (div_q == c_smp_div);
    w_pix_last = (pix_q == c_pix_last);
    w_gap_done = w_fall && (gap_q == c_gap_end);
    w_again    = c_no_gap ? enable : again_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_START;
      ST_START: if (w_fall) state_d = ST_READ;
      ST_READ:  if (w_sample && w_pix_last) state_d = ST_GAP;
      ST_GAP:   if (w_gap_done) state_d = w_again ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_d = '0;
    sclk_d = 1'b0;
    if (state_q != ST_IDLE) begin
      div_d  = w_tick ? '0 : div_q + 1'b1;
      sclk_d = sclk_q ^ w_tick;
    end

    si_d = (state_d == ST_START);

    armed_d = armed_q;
    if (w_sample) armed_d = 1'b0;
    if ((state_q == ST_READ) && w_rise) armed_d = 1'b1;
    if (state_d != ST_READ) armed_d = 1'b0;

    pix_d = pix_q;
    if (w_sample) pix_d = w_pix_last ? '0 : pix_q + 1'b1;

    gap_d   = gap_q;
    again_d = again_q;
    if (state_q != ST_GAP) begin
      gap_d   = '0;
      again_d = 1'b0;
    end else if (w_rise) begin
      again_d = enable;
      if (gap_q != c_gap_end) gap_d = gap_q + 1'b1;
    end

    cap_d  = w_sample;
    last_d = w_sample && w_pix_last;
    data_d = w_sample ? w_sample_val : data_q;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      pix_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      sclk_q  <= 1'b0;
      si_q    <= 1'b0;
      armed_q <= 1'b0;
      again_q <= 1'b0;
      cap_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pix_q   <= pix_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      si_q    <= si_d;
      armed_q <= armed_d;
      again_q <= again_d;
      cap_q   <= cap_d;
      last_q  <= last_d;
    end
  end

  assign sensor_clk     = sclk_q;
  assign sensor_si      = si_q;
  assign pixel_data     = data_q;
  assign pixel_captured = cap_q;
  assign pixel_last     = last_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_linescanner_pixel_capture.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_linescanner_pixel_capture
// Description : Directed self-checking bench for linescanner_pixel_capture
//               (CLK_DIV=2, SAMPLE_DELAY=1, LINE_GAP=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_linescanner_pixel_capture;

`ifdef LINESCANNER_TEST_PATTERN_EN
  localparam int PPL = 300;
`else
  localparam int PPL = 8;
`endif

  logic       axi_aclk = 1'b0;
  logic       axi_aresetn = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic       sensor_clk, sensor_si, pixel_captured, pixel_last, busy;
  logic [7:0] pixel_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] adc_idx = 8'h00;
  logic       adc_pend = 1'b0;
  logic       sclk_prev = 1'b0;

  linescanner_pixel_capture #(
    .CLK_DIV(2), .PIXELS_PER_LINE(PPL), .SAMPLE_DELAY(1), .LINE_GAP(2)
  ) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn), .enable(enable),
    .adc_data(adc_data), .sensor_clk(sensor_clk), .sensor_si(sensor_si),
    .pixel_data(pixel_data), .pixel_captured(pixel_captured),
    .pixel_last(pixel_last), .busy(busy)
  );

  always #5 axi_aclk = ~axi_aclk;

  // ADC model: presents 0x10+index one cycle after each pixel rise
  initial begin
    forever begin
      @(posedge axi_aclk); #1;
      if (adc_pend) begin
        adc_data = 8'h10 + adc_idx;
        adc_idx  = adc_idx + 8'h01;
        adc_pend = 1'b0;
      end
      if (sensor_si) adc_idx = 8'h00;
      else if (sensor_clk && !sclk_prev) adc_pend = 1'b1;
      sclk_prev = sensor_clk;
    end
  end

  task automatic step();
    @(posedge axi_aclk); #1;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    repeat (3) step();
    n_cmp++;
    got = {sensor_clk, sensor_si, pixel_data, pixel_captured, pixel_last, busy};
    if (got !== 13'd0) begin
      n_err++; $display("FAIL reset_held outputs got %h exp 0", got);
    end
    @(negedge axi_aclk) axi_aresetn = 1'b1;
    for (int t = 0; t < 100; t++) begin
      step();
      got = {sensor_clk, sensor_si, pixel_data, pixel_captured, pixel_last, busy};
      n_cmp++;
      if (got !== 13'd0) begin
        n_err++; $display("FAIL reset_idle t=%0d outputs got %h exp 0", t, got);
      end
    end
  endtask

  task automatic test_single_line();
    logic [4:0] exp_v, got_v;
    int p;
    enable = 1'b1; step(); enable = 1'b0;
    for (int t = 0; t < 60; t++) begin
      p = (t - 8) / 4;
      exp_v[4] = (t >= 2) && (t < 44) && (((t - 2) % 4) < 2);
      exp_v[3] = (t < 4);
      exp_v[2] = (t >= 8) && (((t - 8) % 4) == 0) && (p < 8);
      exp_v[1] = exp_v[2] && (p == 7);
      exp_v[0] = (t < 44);
      got_v = {sensor_clk, sensor_si, pixel_captured, pixel_last, busy};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL single_line t=%0d {sclk,si,cap,last,busy} got %b exp %b", t, got_v, exp_v);
      end
      if (exp_v[2]) begin
        n_cmp++;
        if (pixel_data !== 8'h10 + 8'(p)) begin
          n_err++;
          $display("FAIL single_line_data pix=%0d got %h exp %h", p, pixel_data, 8'h10 + 8'(p));
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_v, got_v;
    int tl, p, n_cap, n_last;
    logic in_line;
    n_cap = 0; n_last = 0;
    enable = 1'b1; step();
    for (int t = 0; t < 160; t++) begin
      if (t == 100) enable = 1'b0;
      tl = t % 44;
      p = (tl - 8) / 4;
      in_line = (t < 132);
      exp_v[4] = in_line && (tl >= 2) && (((tl - 2) % 4) < 2);
      exp_v[3] = in_line && (tl < 4);
      exp_v[2] = in_line && (tl >= 8) && (((tl - 8) % 4) == 0) && (p < 8);
      exp_v[1] = exp_v[2] && (p == 7);
      exp_v[0] = in_line;
      got_v = {sensor_clk, sensor_si, pixel_captured, pixel_last, busy};
      n_cap += int'(pixel_captured === 1'b1);
      n_last += int'(pixel_last === 1'b1);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL back_to_back t=%0d {sclk,si,cap,last,busy} got %b exp %b", t, got_v, exp_v);
      end
      if (exp_v[2]) begin
        n_cmp++;
        if (pixel_data !== 8'h10 + 8'(p)) begin
          n_err++;
          $display("FAIL back_to_back_data t=%0d got %h exp %h", t, pixel_data, 8'h10 + 8'(p));
        end
      end
      step();
    end
    n_cmp++;
    if (n_cap != 24) begin
      n_err++; $display("FAIL back_to_back_strobes got %0d exp 24", n_cap);
    end
    n_cmp++;
    if (n_last != 3) begin
      n_err++; $display("FAIL back_to_back_lasts got %0d exp 3", n_last);
    end
  endtask

  task automatic test_enable_drop();
    logic [4:0] exp_v, got_v;
    int p, n_cap;
    n_cap = 0;
    enable = 1'b1; step();
    for (int t = 0; t < 100; t++) begin
      p = (t - 8) / 4;
      exp_v[4] = (t >= 2) && (t < 44) && (((t - 2) % 4) < 2);
      exp_v[3] = (t < 4);
      exp_v[2] = (t >= 8) && (((t - 8) % 4) == 0) && (p < 8);
      exp_v[1] = exp_v[2] && (p == 7);
      exp_v[0] = (t < 44);
      got_v = {sensor_clk, sensor_si, pixel_captured, pixel_last, busy};
      if (pixel_captured === 1'b1) begin
        n_cap++;
        if (n_cap == 3) enable = 1'b0;
      end
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL enable_drop t=%0d {sclk,si,cap,last,busy} got %b exp %b", t, got_v, exp_v);
      end
      step();
    end
    n_cmp++;
    if (n_cap != 8) begin
      n_err++; $display("FAIL enable_drop_strobes got %0d exp 8", n_cap);
    end
  endtask

  task automatic test_reset_midline();
    logic [12:0] got;
    logic [4:0]  exp_v, got_v;
    int n_cap, p, guard;
    n_cap = 0; guard = 0;
    enable = 1'b1; step(); enable = 1'b0;
    while (n_cap < 5 && guard < 100) begin
      if (pixel_captured === 1'b1) n_cap++;
      if (n_cap < 5) step();
      guard++;
    end
    n_cmp++;
    if (n_cap != 5) begin
      n_err++; $display("FAIL reset_mid_wait strobes got %0d exp 5", n_cap);
    end
    #2 axi_aresetn = 1'b0;
    #1;
    got = {sensor_clk, sensor_si, pixel_data, pixel_captured, pixel_last, busy};
    n_cmp++;
    if (got !== 13'd0) begin
      n_err++; $display("FAIL reset_mid_async outputs got %h exp 0", got);
    end
    enable = 1'b1;
    repeat (2) @(posedge axi_aclk);
    @(negedge axi_aclk) axi_aresetn = 1'b1;
    step();
    enable = 1'b0;
    for (int t = 0; t < 60; t++) begin
      p = (t - 8) / 4;
      exp_v[4] = (t >= 2) && (t < 44) && (((t - 2) % 4) < 2);
      exp_v[3] = (t < 4);
      exp_v[2] = (t >= 8) && (((t - 8) % 4) == 0) && (p < 8);
      exp_v[1] = exp_v[2] && (p == 7);
      exp_v[0] = (t < 44);
      got_v = {sensor_clk, sensor_si, pixel_captured, pixel_last, busy};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_restart t=%0d {sclk,si,cap,last,busy} got %b exp %b", t, got_v, exp_v);
      end
      if (exp_v[2]) begin
        n_cmp++;
        if (pixel_data !== 8'h10 + 8'(p)) begin
          n_err++;
          $display("FAIL reset_mid_data pix=%0d got %h exp %h", p, pixel_data, 8'h10 + 8'(p));
        end
      end
      step();
    end
  endtask

  task automatic test_pattern();
    int k;
    logic [31:0] kv;
    logic [7:0]  last_val;
    k = 0; last_val = 8'hFF;
    enable = 1'b1; step(); enable = 1'b0;
    for (int t = 0; t < 1400; t++) begin
      if (pixel_captured === 1'b1) begin
        kv = 32'(k);
        n_cmp++;
        if (pixel_data !== kv[7:0]) begin
          n_err++; $display("FAIL pattern_data pix=%0d got %h exp %h", k, pixel_data, kv[7:0]);
        end
        n_cmp++;
        if (pixel_last !== (k == PPL - 1)) begin
          n_err++; $display("FAIL pattern_last pix=%0d got %b exp %b", k, pixel_last, (k == PPL - 1));
        end
        if (pixel_last === 1'b1) last_val = pixel_data;
        k++;
      end
      step();
    end
    n_cmp++;
    if (k != PPL) begin
      n_err++; $display("FAIL pattern_count got %0d exp %0d", k, PPL);
    end
    n_cmp++;
    if (last_val !== 8'd43) begin
      n_err++; $display("FAIL pattern_last_value got %0d exp 43", last_val);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL pattern_idle busy got %b exp 0", busy);
    end
  endtask

  initial begin
    test_reset();
`ifdef LINESCANNER_TEST_PATTERN_EN
    test_pattern();
`else
    test_single_line();
    test_back_to_back();
    test_enable_drop();
    test_reset_midline();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
